// File: rtl/gf193_trinomial_reducer_if.sv
// Handshake bundle between a producer of raw 2M-1 bit carry-less products
// and the trinomial reducer.
//   in_valid / in_ready / prod  : product input channel (producer -> reducer)
//   out_valid / out_ready / res : reduced field element channel (reducer -> consumer)
// master: the environment side (drives prod and out_ready).
// slave : the reducer side.
interface gf193_trinomial_reducer_if #(
    parameter int M = 193
);
    logic             in_valid;
    logic             in_ready;
    logic [2*M-2:0]   prod;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     res;

    modport master (
        output in_valid,
        output prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  res
    );

    modport slave (
        input  in_valid,
        input  prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output res
    );
endinterface

// File: rtl/gf193_trinomial_reducer.sv
// Sequential reducer of a raw GF(2) product modulo the trinomial
// f(x) = x^M + x^K + 1. One XOR fold per clock; stops as soon as the upper
// part of the accumulator is zero (at most two folds for 1 <= K <= (M-1)/2).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : slave side of gf193_trinomial_reducer_if
//          (in_valid/in_ready/prod in, out_valid/out_ready/res out)
//   busy : high while the block is in the FOLD state
module gf193_trinomial_reducer #(
    parameter int M = 193,
    parameter int K = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    gf193_trinomial_reducer_if.slave      bus,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [2*M-2:0]  acc_reg;
    logic [M-1:0]    res_reg;

    logic [M-2:0]    hi;
    logic [M-1:0]    lo;
    logic            hi_zero;
    logic [M+K-2:0]  folded;
    logic [2*M-2:0]  acc_folded;
    logic            in_ready_int;
    logic            accept;

    assign hi      = acc_reg[2*M-2:M];
    assign lo      = acc_reg[M-1:0];
    assign hi_zero = (hi == '0);

    // x^M == x^K + 1, so the upper part hi*x^M contributes hi + hi*x^K.
    // The sum is M+K-1 bits wide; the bits above M-1 are folded again on
    // the next cycle, so the result is zero-extended rather than truncated.
    assign folded     = {{(K-1){1'b0}}, lo}
                      ^ {{K{1'b0}}, hi}
                      ^ {hi, {K{1'b0}}};
    assign acc_folded = {{(M-K){1'b0}}, folded};

    assign accept = bus.in_valid && in_ready_int;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                acc_reg <= bus.prod;
            end else if (state_reg == FOLD && !hi_zero) begin
                acc_reg <= acc_folded;
            end
            if (state_reg == FOLD && hi_zero) begin
                res_reg <= lo;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = FOLD;
                end
            end
            FOLD: begin
                if (hi_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = bus.in_valid ? FOLD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state. in_ready follows out_ready
    // in DONE so a new product can be taken in the same cycle the result
    // leaves; out_valid and res never depend combinationally on inputs.
    always_comb begin
        in_ready_int  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state_reg)
            IDLE: in_ready_int = 1'b1;
            FOLD: busy = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                in_ready_int  = bus.out_ready;
            end
            default: in_ready_int = 1'b0;
        endcase
    end

    assign bus.in_ready = in_ready_int;
    assign bus.res      = res_reg;

`ifndef SYNTHESIS
    // FOLD cycles per transaction: at most two folds plus the final zero check.
    logic [2:0] fold_visits_reg;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            fold_visits_reg <= '0;
        end else if (state_reg == FOLD && fold_visits_reg != 3'd7) begin
            fold_visits_reg <= fold_visits_reg + 3'd1;
        end
    end

    fold_count_bound: assert property (@(posedge clk) disable iff (rst)
        fold_visits_reg <= 3'd3);
`endif

endmodule

// File: tb/tb_gf193_trinomial_reducer.sv
// Scoreboard bench for gf193_trinomial_reducer: the driver pushes expected
// results (value, fold count, accept cycle) when a product is accepted; an
// independent monitor pops and compares every completed output transfer.
module tb_gf193_trinomial_reducer;

    localparam int M = 193;
    localparam int K = 15;
    localparam int W = 2*M-1;

    typedef struct {
        logic [M-1:0] res;
        int           n;
        int           acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];

    gf193_trinomial_reducer_if #(.M(M)) bus ();

    gf193_trinomial_reducer #(.M(M), .K(K)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference reduction: clear set bits from the top down, x^i -> x^(i-M+K) + x^(i-M).
    function automatic logic [M-1:0] ref_reduce(input logic [W-1:0] p);
        logic [W-1:0] a;
        a = p;
        for (int i = W-1; i >= M; i--) begin
            if (a[i]) begin
                a[i]         = 1'b0;
                a[i-M+K]     = ~a[i-M+K];
                a[i-M]       = ~a[i-M];
            end
        end
        return a[M-1:0];
    endfunction

    function automatic int ref_folds(input logic [W-1:0] p);
        if (p[W-1:M] == '0) return 0;
        if (p[W-1:2*M-K] == '0) return 1;
        return 2;
    endfunction

    function automatic logic [W-1:0] bit_at(input int i);
        logic [W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit           presenting = 1'b0;
    bit           stall      = 1'b0;
    logic [M-1:0] stall_res;
    int           start_cyc  = 0;
    int           busy_cnt   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            presenting = 1'b0;
            stall      = 1'b0;
            busy_cnt   = 0;
        end else begin
            if (busy) busy_cnt++;
            if (stall) begin
                checks++;
                if (!bus.out_valid || bus.res !== stall_res) begin
                    errors++;
                    $display("FAIL hold: out_valid=%0b res=%h required out_valid=1 res=%h",
                             bus.out_valid, bus.res, stall_res);
                end
            end
            if (bus.out_valid && !presenting) begin
                presenting = 1'b1;
                start_cyc  = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: res=%h presented with no pending transaction", bus.res);
                end else begin
                    e = sb.pop_front();
                    if (bus.res !== e.res) begin
                        errors++;
                        $display("FAIL res: got %h required %h", bus.res, e.res);
                    end
                    checks++;
                    if (start_cyc - e.acc_cyc != 2 + e.n) begin
                        errors++;
                        $display("FAIL latency: got %0d required %0d", start_cyc - e.acc_cyc, 2 + e.n);
                    end
                    checks++;
                    if (busy_cnt != e.n + 1) begin
                        errors++;
                        $display("FAIL busy_cycles: got %0d required %0d", busy_cnt, e.n + 1);
                    end
                end
                presenting = 1'b0;
                busy_cnt   = 0;
            end
            stall     = bus.out_valid && !bus.out_ready;
            stall_res = bus.res;
        end
    end

    // ---------------- random backpressure ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [W-1:0] p, input logic [M-1:0] r, input int n,
                        input bit track, output int acc_cyc);
        exp_t e;
        int   t;
        t = 0;
        acc_cyc = -1;
        bus.in_valid = 1'b1;
        bus.prod     = p;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles required 1", t);
        end else begin
            acc_cyc = cyc;
            if (track) begin
                e.res     = r;
                e.n       = n;
                e.acc_cyc = cyc;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.out_valid) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.res !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: in_ready=%0b out_valid=%0b busy=%0b res=%h required 1 0 0 0",
                     tag, bus.in_ready, bus.out_valid, busy, bus.res);
        end
    endtask

    // ---------------- directed vectors ----------------
    localparam int ND = 7;
    int           d_bit [ND] = '{0, 193, 384, 200, 192, 370, 371};
    logic [M-1:0] d_res [ND];
    int           d_n   [ND] = '{0, 1, 2, 1, 0, 1, 2};

    initial begin
        int           a1;
        int           a2;
        logic [W-1:0] p;
        logic [W-1:0] acc_exp;
        logic [M-1:0] r;

        // Hand-computed reductions of single monomials
        r = '0; r[0] = 1'b1;                               d_res[0] = r;
        r = '0; r[15] = 1'b1; r[0] = 1'b1;                 d_res[1] = r;
        r = '0; r[191] = 1'b1; r[28] = 1'b1; r[13] = 1'b1; d_res[2] = r;
        r = '0; r[22] = 1'b1; r[7] = 1'b1;                 d_res[3] = r;
        r = '0; r[192] = 1'b1;                             d_res[4] = r;
        r = '0; r[192] = 1'b1; r[177] = 1'b1;              d_res[5] = r;
        r = '0; r[178] = 1'b1; r[15] = 1'b1; r[0] = 1'b1;  d_res[6] = r;

        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("reset_state");

        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            send(bit_at(d_bit[i]), d_res[i], d_n[i], 1'b1, a1);
            bus.in_valid = 1'b0;
            drain();
        end

        // Back-to-back: second product accepted in the DONE cycle of the first
        send(bit_at(193), d_res[1], 1, 1'b1, a1);
        send(bit_at(200), d_res[3], 1, 1'b1, a2);
        bus.in_valid = 1'b0;
        checks++;
        if (a2 - a1 != 3) begin
            errors++;
            $display("FAIL back_to_back_accept: gap %0d cycles required 3", a2 - a1);
        end
        drain();

        // Reset during the second fold of x^384; the partial result must vanish
        send(bit_at(384), d_res[2], 2, 1'b0, a1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        acc_exp = '0;
        acc_exp[206] = 1'b1;
        acc_exp[191] = 1'b1;
        checks++;
        if (dut.acc_reg !== acc_exp) begin
            errors++;
            $display("FAIL acc_after_fold1: got %h required %h", dut.acc_reg, acc_exp);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        send(bit_at(0), d_res[0], 0, 1'b1, a1);
        bus.in_valid = 1'b0;
        drain();

        // Random products under random backpressure, checked against ref_reduce
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int w = 0; w < W; w += 32) begin
                p[w +: 32] = 32'($urandom);
            end
            if (i % 3 == 1) p[W-1:2*M-K] = '0;
            if (i % 3 == 2) p[W-1:M] = '0;
            send(p, ref_reduce(p), ref_folds(p), 1'b1, a1);
            if ($urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
